// File: rtl/weight_buffer_writer.sv
// rtl/weight_buffer_writer.sv - streams LSTM weight then bias words into their RAMs at sequential addresses
module weight_buffer_writer #(
    parameter int hidden_size    = 1,
    parameter int DATA_WIDTH     = 16,
    parameter int ADDR_WIDTHAD   = ($clog2(hidden_size*hidden_size*4) < 1) ? 1 : $clog2(hidden_size*hidden_size*4),
    parameter int ADDR_WIDTHBIAS = ($clog2(hidden_size*4) < 1) ? 1 : $clog2(hidden_size*4)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load_start,
    input  logic [DATA_WIDTH-1:0]     s_data,
    input  logic                      s_valid,
    output logic                      s_ready,
    output logic                      wt_we,
    output logic [ADDR_WIDTHAD-1:0]   wt_addr,
    output logic [DATA_WIDTH-1:0]     wt_wdata,
    output logic                      bias_we,
    output logic [ADDR_WIDTHBIAS-1:0] bias_addr,
    output logic [DATA_WIDTH-1:0]     bias_wdata,
    output logic                      load_busy,
    output logic                      load_done,
    output logic                      weights_valid
);

    localparam int N_W = hidden_size * hidden_size * 4;
    localparam int N_B = hidden_size * 4;
    localparam int CW  = (ADDR_WIDTHAD > ADDR_WIDTHBIAS) ? ADDR_WIDTHAD : ADDR_WIDTHBIAS;
    localparam logic [CW-1:0] LAST_W = CW'(N_W - 1);
    localparam logic [CW-1:0] LAST_B = CW'(N_B - 1);

    typedef enum logic [1:0] {S_IDLE, S_WEIGHT, S_BIAS, S_DONE} state_t;

    state_t                    state_q, state_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic                      s_ready_q, s_ready_d;
    logic                      wt_we_q, wt_we_d;
    logic [ADDR_WIDTHAD-1:0]   wt_addr_q, wt_addr_d;
    logic [DATA_WIDTH-1:0]     wt_wdata_q, wt_wdata_d;
    logic                      bias_we_q, bias_we_d;
    logic [ADDR_WIDTHBIAS-1:0] bias_addr_q, bias_addr_d;
    logic [DATA_WIDTH-1:0]     bias_wdata_q, bias_wdata_d;
    logic                      load_done_q, load_done_d;
    logic                      weights_valid_q, weights_valid_d;
    logic                      beat;

    assign beat = s_valid && s_ready_q;

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        wt_we_d         = 1'b0;
        wt_addr_d       = wt_addr_q;
        wt_wdata_d      = wt_wdata_q;
        bias_we_d       = 1'b0;
        bias_addr_d     = bias_addr_q;
        bias_wdata_d    = bias_wdata_q;
        load_done_d     = 1'b0;
        weights_valid_d = weights_valid_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (load_start) begin
                    state_d         = S_WEIGHT;
                    cnt_d           = '0;
                    weights_valid_d = 1'b0;
                end
            end
            S_WEIGHT: begin
                if (beat) begin
                    wt_we_d    = 1'b1;
                    wt_addr_d  = cnt_q[ADDR_WIDTHAD-1:0];
                    wt_wdata_d = s_data;
                    if (cnt_q == LAST_W) begin
                        state_d = S_BIAS;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_BIAS: begin
                if (beat) begin
                    bias_we_d    = 1'b1;
                    bias_addr_d  = cnt_q[ADDR_WIDTHBIAS-1:0];
                    bias_wdata_d = s_data;
                    if (cnt_q == LAST_B) begin
                        state_d         = S_DONE;
                        load_done_d     = 1'b1;
                        weights_valid_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Ready tracks the state being entered so it is already high on the first load cycle.
        s_ready_d = (state_d == S_WEIGHT) || (state_d == S_BIAS);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            cnt_q           <= '0;
            s_ready_q       <= 1'b0;
            wt_we_q         <= 1'b0;
            wt_addr_q       <= '0;
            wt_wdata_q      <= '0;
            bias_we_q       <= 1'b0;
            bias_addr_q     <= '0;
            bias_wdata_q    <= '0;
            load_done_q     <= 1'b0;
            weights_valid_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            s_ready_q       <= s_ready_d;
            wt_we_q         <= wt_we_d;
            wt_addr_q       <= wt_addr_d;
            wt_wdata_q      <= wt_wdata_d;
            bias_we_q       <= bias_we_d;
            bias_addr_q     <= bias_addr_d;
            bias_wdata_q    <= bias_wdata_d;
            load_done_q     <= load_done_d;
            weights_valid_q <= weights_valid_d;
        end
    end

    assign s_ready       = s_ready_q;
    assign wt_we         = wt_we_q;
    assign wt_addr       = wt_addr_q;
    assign wt_wdata      = wt_wdata_q;
    assign bias_we       = bias_we_q;
    assign bias_addr     = bias_addr_q;
    assign bias_wdata    = bias_wdata_q;
    assign load_busy     = (state_q == S_WEIGHT) || (state_q == S_BIAS);
    assign load_done     = load_done_q;
    assign weights_valid = weights_valid_q;

endmodule
